// File: rtl/msg_schedule_ctrl.sv
// SHA-256 message-schedule sequencer: loads M[0..15] serially, then
// streams W[0..ROUNDS-1] from a 16-word sliding window.
module msg_schedule_ctrl #(
   parameter int ROUNDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        abort,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_word,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_w,
   output logic [5:0]  out_t,
   output logic        done
);

   typedef enum logic {
      LOAD,
      RUN
   } state_e;

   localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

   state_e      state_q, state_d;
   logic [3:0]  load_cnt_q, load_cnt_d;
   logic [5:0]  t_q, t_d;
   logic        done_q, done_d;
   logic [31:0] win_q [16];
   logic [31:0] win_d [16];
   logic [31:0] w_next;

   function automatic logic [31:0] sig0(
      input logic [31:0] x
   );
      sig0 = {x[6:0], x[31:7]}
           ^ {x[17:0], x[31:18]}
           ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] sig1(
      input logic [31:0] x
   );
      sig1 = {x[16:0], x[31:17]}
           ^ {x[18:0], x[31:19]}
           ^ {10'd0, x[31:10]};
   endfunction

   // W[t+16] from the window holding W[t..t+15]
   assign w_next = win_q[0]
                 + sig0(win_q[1])
                 + win_q[9]
                 + sig1(win_q[14]);

   assign in_ready  = (state_q == LOAD);
   assign out_valid = (state_q == RUN);
   assign out_w     = win_q[0];
   assign out_t     = t_q;
   assign done      = done_q;

   always_comb begin
      state_d    = state_q;
      load_cnt_d = load_cnt_q;
      t_d        = t_q;
      done_d     = 1'b0;
      win_d      = win_q;
      // abort wins over any handshake in the same cycle
      if (abort) begin
         state_d    = LOAD;
         load_cnt_d = 4'd0;
         t_d        = 6'd0;
      end else begin
         case (state_q)
            LOAD: begin
               if (in_valid) begin
                  win_d[load_cnt_q] = in_word;
                  load_cnt_d = load_cnt_q + 4'd1;
                  if (load_cnt_q == 4'd15) begin
                     state_d    = RUN;
                     t_d        = 6'd0;
                     load_cnt_d = 4'd0;
                  end
               end
            end
            RUN: begin
               if (out_ready) begin
                  for (int i = 0; i < 15; i++) begin
                     win_d[i] = win_q[i+1];
                  end
                  win_d[15] = w_next;
                  t_d = t_q + 6'd1;
                  if (t_q == LAST_T) begin
                     state_d = LOAD;
                     t_d     = 6'd0;
                     done_d  = 1'b1;
                  end
               end
            end
            default: begin
               state_d = LOAD;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= LOAD;
         load_cnt_q <= 4'd0;
         t_q        <= 6'd0;
         done_q     <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            win_q[i] <= 32'd0;
         end
      end else begin
         state_q    <= state_d;
         load_cnt_q <= load_cnt_d;
         t_q        <= t_d;
         done_q     <= done_d;
         win_q      <= win_d;
      end
   end

endmodule

// File: tb/tb_msg_schedule_ctrl.sv
// Bench for msg_schedule_ctrl: golden W[] array model, known-answer
// table for the "abc" block, stalls, abort and async reset sequences.
module tb_msg_schedule_ctrl;

   localparam int ROUNDS = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        abort;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_w;
   logic [5:0]  out_t;
   logic        done;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] blk  [16];
   logic [31:0] gold [64];
   logic [31:0] cap  [64];

   typedef struct {
      int          t;
      logic [31:0] w;
   } vec_t;

   vec_t abc_tab [7];

   msg_schedule_ctrl #(.ROUNDS(ROUNDS)) dut (
      .clk(clk),
      .reset(reset),
      .abort(abort),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_word(in_word),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_w(out_w),
      .out_t(out_t),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, got, exp);
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x,
                                        input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] s0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] s1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // textbook full-array expansion
   task automatic make_gold();
      for (int t = 0; t < 64; t++) begin
         if (t < 16) gold[t] = blk[t];
         else gold[t] = s1(gold[t-2]) + gold[t-7]
                      + s0(gold[t-15]) + gold[t-16];
      end
   endtask

   task automatic rand_blk();
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
   endtask

   task automatic abc_blk();
      for (int i = 0; i < 16; i++) blk[i] = 32'd0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
   endtask

   // entered and left at a negedge
   task automatic load_block();
      for (int i = 0; i < 16; i++) begin
         check("ld_in_ready", 32'(in_ready), 32'd1);
         check("ld_out_valid", 32'(out_valid), 32'd0);
         in_valid = 1'b1;
         in_word  = blk[i];
         @(negedge clk);
      end
   endtask

   task automatic drain(input int pct, input bit junk,
                        input int abort_at, input int rst_at);
      int et = 0;
      int cyc = 0;
      bit fin = 0;
      bit stalled = 0;
      logic [31:0] pw;
      logic [5:0]  pt;
      make_gold();
      check("w0_latency", 32'(out_valid), 32'd1);
      while (!fin) begin
         in_valid = junk;
         in_word  = 32'hDEADBEEF;
         check("run_in_ready", 32'(in_ready), 32'd0);
         check("run_done", 32'(done), 32'd0);
         check("run_out_valid", 32'(out_valid), 32'd1);
         check("out_t", 32'(out_t), 32'(et));
         check("out_w", out_w, gold[et]);
         if (stalled) begin
            check("stall_w", out_w, pw);
            check("stall_t", 32'(out_t), 32'(pt));
         end
         cap[et] = out_w;
         pw = out_w;
         pt = out_t;
         if (et == rst_at) begin
            out_ready = 1'b0;
            #2 reset = 1'b1;
            #1;
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_out_w", out_w, 32'd0);
            check("rst_out_t", 32'(out_t), 32'd0);
            #1 reset = 1'b0;
            @(negedge clk);
            fin = 1;
         end else if (et == abort_at) begin
            out_ready = 1'b1;
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            out_ready = 1'b0;
            check("ab_out_valid", 32'(out_valid), 32'd0);
            check("ab_done", 32'(done), 32'd0);
            check("ab_in_ready", 32'(in_ready), 32'd1);
            check("ab_out_t", 32'(out_t), 32'd0);
            @(negedge clk);
            check("ab_done2", 32'(done), 32'd0);
            fin = 1;
         end else begin
            out_ready = ($urandom_range(99) < pct);
            stalled = !out_ready;
            if (out_ready) et++;
            @(negedge clk);
            cyc++;
            if (et == ROUNDS) begin
               check("end_done", 32'(done), 32'd1);
               check("end_out_valid", 32'(out_valid), 32'd0);
               check("end_in_ready", 32'(in_ready), 32'd1);
               check("end_out_t", 32'(out_t), 32'd0);
               if (pct >= 100) check("no_bubble", 32'(cyc), 32'(ROUNDS));
               fin = 1;
            end else if (cyc > 5000) begin
               check("drain_timeout", 32'd0, 32'd1);
               fin = 1;
            end
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      abc_tab[0] = '{0,  32'h61626380};
      abc_tab[1] = '{1,  32'h00000000};
      abc_tab[2] = '{8,  32'h00000000};
      abc_tab[3] = '{14, 32'h00000000};
      abc_tab[4] = '{15, 32'h00000018};
      abc_tab[5] = '{16, 32'h61626380};
      abc_tab[6] = '{17, 32'h000F0000};

      reset = 1'b0;
      abort = 1'b0;
      in_valid = 1'b0;
      in_word = 32'd0;
      out_ready = 1'b0;
      #1 reset = 1'b1;
      #2;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_w", out_w, 32'd0);
      check("rst_out_t", 32'(out_t), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      abc_blk();
      load_block();
      drain(100, 0, -1, -1);
      for (int i = 0; i < 7; i++) begin
         check($sformatf("abc_W%0d", abc_tab[i].t),
               cap[abc_tab[i].t], abc_tab[i].w);
      end
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);

      abc_blk();
      load_block();
      drain(50, 0, -1, -1);

      rand_blk();
      load_block();
      drain(70, 1, -1, -1);

      rand_blk();
      load_block();
      drain(100, 0, -1, -1);
      rand_blk();
      load_block();
      drain(100, 0, -1, -1);

      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_word = $urandom;
         @(negedge clk);
      end
      abort = 1'b1;
      in_word = 32'hCAFEF00D;
      @(negedge clk);
      abort = 1'b0;
      in_valid = 1'b0;
      check("ld_ab_in_ready", 32'(in_ready), 32'd1);
      check("ld_ab_out_valid", 32'(out_valid), 32'd0);
      rand_blk();
      load_block();
      drain(100, 0, -1, -1);

      rand_blk();
      load_block();
      drain(100, 0, 30, -1);
      rand_blk();
      load_block();
      drain(80, 0, -1, -1);

      rand_blk();
      load_block();
      drain(100, 0, -1, 40);
      rand_blk();
      load_block();
      drain(60, 0, -1, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
